// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC, single-outstanding instruction fetch FSM and IF_ID register feeding the decoder.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallIn,
  input  logic        redirectEnable,
  input  logic [31:0] redirectAddr,
  output logic        memReqValid,
  output logic [31:0] memReqAddr,
  input  logic        memReqReady,
  input  logic        memRespValid,
  input  logic [31:0] memRespData,
  output logic [31:0] inst,
  output logic [31:0] pcOut,
  output logic        instValid,
  output logic        resetOut
);
  typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;
  state_t state, state_n;
  logic [31:0] pc, pc_n, skid, skid_n, inst_n, pc_out_n;
  logic valid_n, reset_out_n;
  assign memReqValid = state == S_REQ;
  assign memReqAddr = pc;
  always_comb begin
    state_n = state;
    pc_n = pc;
    skid_n = skid;
    inst_n = inst;
    pc_out_n = pcOut;
    valid_n = instValid;
    reset_out_n = resetOut;
    if (redirectEnable) begin
      // a redirect flushes IF_ID even under stall; any fetch still in flight must be dropped
      pc_n = redirectAddr & ~32'd3;
      inst_n = NOP_INST;
      valid_n = 1'b0;
      case (state)
        S_REQ:   state_n = memReqReady ? S_DROP : S_REQ;
        S_WAIT:  state_n = memRespValid ? S_REQ : S_DROP;
        S_DROP:  state_n = memRespValid ? S_REQ : S_DROP;
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state)
        S_BOOT: state_n = S_REQ;
        S_REQ:  state_n = memReqReady ? S_WAIT : S_REQ;
        S_WAIT: begin
          if (memRespValid && !stallIn) begin
            inst_n = memRespData;
            pc_out_n = pc;
            valid_n = 1'b1;
            reset_out_n = 1'b0;
            pc_n = pc + 32'd4;
            state_n = S_REQ;
          end else if (memRespValid) begin
            skid_n = memRespData;
            state_n = S_HOLD;
          end else if (!stallIn) begin
            inst_n = NOP_INST;
            valid_n = 1'b0;
          end
        end
        S_HOLD: begin
          if (!stallIn) begin
            inst_n = skid;
            pc_out_n = pc;
            valid_n = 1'b1;
            reset_out_n = 1'b0;
            pc_n = pc + 32'd4;
            state_n = S_REQ;
          end
        end
        S_DROP:  state_n = memRespValid ? S_REQ : S_DROP;
        default: state_n = S_BOOT;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_BOOT;
      pc <= RESET_PC;
      skid <= 32'd0;
      inst <= NOP_INST;
      pcOut <= RESET_PC;
      instValid <= 1'b0;
      resetOut <= 1'b1;
    end else begin
      state <= state_n;
      pc <= pc_n;
      skid <= skid_n;
      inst <= inst_n;
      pcOut <= pc_out_n;
      instValid <= valid_n;
      resetOut <= reset_out_n;
    end
  end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of fetch, latency, stall, redirect, PC wrap and async reset.
module tb_inst_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, reset = 1'b0, stallIn = 1'b0, redirectEnable = 1'b0;
  logic memReqReady = 1'b0, memRespValid = 1'b0;
  logic [31:0] redirectAddr = 32'd0, memRespData = 32'd0;
  logic memReqValid, instValid, resetOut;
  logic [31:0] memReqAddr, inst, pcOut;
  logic w_valid, w_inst_valid, w_reset_out;
  logic [31:0] w_addr, w_inst, w_pc_out;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  inst_fetch_unit dut (
    .clk(clk), .reset(reset), .stallIn(stallIn), .redirectEnable(redirectEnable),
    .redirectAddr(redirectAddr), .memReqValid(memReqValid), .memReqAddr(memReqAddr),
    .memReqReady(memReqReady), .memRespValid(memRespValid), .memRespData(memRespData),
    .inst(inst), .pcOut(pcOut), .instValid(instValid), .resetOut(resetOut)
  );
  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .stallIn(stallIn), .redirectEnable(redirectEnable),
    .redirectAddr(redirectAddr), .memReqValid(w_valid), .memReqAddr(w_addr),
    .memReqReady(memReqReady), .memRespValid(memRespValid), .memRespData(memRespData),
    .inst(w_inst), .pcOut(w_pc_out), .instValid(w_inst_valid), .resetOut(w_reset_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic if_id(input string tag, input logic [31:0] i, input logic [31:0] p, input logic v);
    check({tag, ".inst"}, inst, i);
    check({tag, ".pc"}, pcOut, p);
    check({tag, ".valid"}, {31'd0, instValid}, {31'd0, v});
  endtask
  task automatic req(input string tag, input logic v, input logic [31:0] a);
    check({tag, ".reqv"}, {31'd0, memReqValid}, {31'd0, v});
    if (v) check({tag, ".addr"}, memReqAddr, a);
  endtask
  initial begin
    #1 reset = 1'b1;
    #1;
    if_id("rst", NOP, 32'd0, 1'b0);
    check("rst.resetOut", {31'd0, resetOut}, 32'd1);
    req("rst", 1'b0, 32'd0);
    step();
    reset = 1'b0;
    step();
    req("boot", 1'b1, 32'd0);
    check("wrap.addr0", w_addr, 32'hFFFF_FFFC);
    memReqReady = 1'b1;
    step();
    req("t1.wait", 1'b0, 32'd0);
    check("t1.resetOut_hi", {31'd0, resetOut}, 32'd1);
    memReqReady = 1'b0; memRespValid = 1'b1; memRespData = 32'h0050_0093;
    step();
    if_id("t1", 32'h0050_0093, 32'd0, 1'b1);
    check("t1.resetOut_lo", {31'd0, resetOut}, 32'd0);
    req("t1.next", 1'b1, 32'd4);
    check("wrap.pc", w_pc_out, 32'hFFFF_FFFC);
    check("wrap.next", w_addr, 32'd0);
    memRespValid = 1'b0; memReqReady = 1'b1;
    step();
    memReqReady = 1'b0;
    step();
    if_id("t2.bub1", NOP, 32'd0, 1'b0);
    req("t2.bub1", 1'b0, 32'd0);
    step();
    if_id("t2.bub2", NOP, 32'd0, 1'b0);
    req("t2.bub2", 1'b0, 32'd0);
    memRespValid = 1'b1; memRespData = 32'h1111_1111;
    step();
    if_id("t2.A", 32'h1111_1111, 32'd4, 1'b1);
    req("t2.A", 1'b1, 32'd8);
    memRespValid = 1'b0; memReqReady = 1'b1;
    step();
    memReqReady = 1'b0;
    step();
    if_id("t2.bub3", NOP, 32'd4, 1'b0);
    step();
    req("t2.bub4", 1'b0, 32'd0);
    memRespValid = 1'b1; memRespData = 32'h2222_2222;
    step();
    if_id("t2.B", 32'h2222_2222, 32'd8, 1'b1);
    req("t2.B", 1'b1, 32'd12);
    memRespValid = 1'b0; memReqReady = 1'b1; stallIn = 1'b1;
    step();
    req("t3.wait", 1'b0, 32'd0);
    memReqReady = 1'b0; memRespValid = 1'b1; memRespData = 32'hDEAD_BEEF;
    step();
    memRespValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if_id("t3.hold", 32'h2222_2222, 32'd8, 1'b1);
      req("t3.hold", 1'b0, 32'd0);
      step();
    end
    if_id("t3.hold4", 32'h2222_2222, 32'd8, 1'b1);
    stallIn = 1'b0;
    step();
    if_id("t3.rel", 32'hDEAD_BEEF, 32'd12, 1'b1);
    req("t3.rel", 1'b1, 32'd16);
    memReqReady = 1'b1;
    step();
    memReqReady = 1'b0; redirectEnable = 1'b1; redirectAddr = 32'h0000_0103;
    step();
    if_id("t4.flush", NOP, 32'd12, 1'b0);
    req("t4.drop", 1'b0, 32'd0);
    redirectEnable = 1'b0; memRespValid = 1'b1; memRespData = 32'hBAD0_BAD0;
    step();
    memRespValid = 1'b0;
    if_id("t4.discard", NOP, 32'd12, 1'b0);
    req("t4.target", 1'b1, 32'h0000_0100);
    memReqReady = 1'b1;
    step();
    memReqReady = 1'b0;
    reset = 1'b1;
    #1;
    if_id("t5.async", NOP, 32'd0, 1'b0);
    check("t5.resetOut", {31'd0, resetOut}, 32'd1);
    req("t5.async", 1'b0, 32'd0);
    step();
    reset = 1'b0;
    step();
    req("t5.boot", 1'b1, 32'd0);
    memReqReady = 1'b1;
    step();
    check("t5.resetOut_wait", {31'd0, resetOut}, 32'd1);
    memReqReady = 1'b0; memRespValid = 1'b1; memRespData = 32'h00A0_0113;
    step();
    memRespValid = 1'b0;
    if_id("t5.load", 32'h00A0_0113, 32'd0, 1'b1);
    check("t5.resetOut_lo", {31'd0, resetOut}, 32'd0);
    req("t5.next", 1'b1, 32'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
